// File: rtl/instr_sequencer_if.sv
// -----------------------------------------------------------------------------
// instr_sequencer_if
//   Bundles the program-memory fetch bus and the decoder/execution-unit
//   control lines that connect to the instruction sequencer.
//
//   Signals:
//     mem_rd     program memory read request, addressed by pc
//     mem_valid  mem_data valid
//     mem_data   16-bit instruction word from program memory
//     pc         program counter (address of the current instruction)
//     instr_out  registered instruction word for the decoder
//     ir_load    one-cycle load strobe to the decoder IRin
//     exec_en    gates the decoder start lines to the execution units
//     unit_done  per-unit completion pulses
//
//   Modports:
//     master  the sequencer side
//     slave   memory / decoder / execution-unit side
// -----------------------------------------------------------------------------
interface instr_sequencer_if #(
    parameter int PC_W      = 8,
    parameter int NUM_UNITS = 7
) ();
    logic                 mem_rd;
    logic                 mem_valid;
    logic [15:0]          mem_data;
    logic [PC_W-1:0]      pc;
    logic [15:0]          instr_out;
    logic                 ir_load;
    logic                 exec_en;
    logic [NUM_UNITS-1:0] unit_done;

    modport master (
        output mem_rd, pc, instr_out, ir_load, exec_en,
        input  mem_valid, mem_data, unit_done
    );

    modport slave (
        input  mem_rd, pc, instr_out, ir_load, exec_en,
        output mem_valid, mem_data, unit_done
    );
endinterface

// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
//   Fetch / load / decode / execute controller. Reads 16-bit instruction
//   words from program memory, strobes the decoder IRin load, holds the
//   decoder start lines enabled while an execution unit runs, owns the
//   program counter and parks on HALT.
//
//   Optional feature: define SEQ_WATCHDOG_EN to build the execution
//   watchdog. Without it, fault is tied low and EXEC waits indefinitely.
//
//   Ports:
//     clk     system clock, rising edge
//     rst_n   asynchronous active-low reset
//     run     level; high lets the sequencer fetch the next instruction
//     bus     instr_sequencer_if.master (memory bus + decoder controls)
//     halted  HALT executed
//     fault   watchdog expired
//     state   current FSM state (debug)
//
//   Parameters:
//     PC_W       program counter width (wraps modulo 2^PC_W)
//     NUM_UNITS  number of execution units
//     WAIT_MAX   EXEC cycles allowed before fault (watchdog build only)
// -----------------------------------------------------------------------------
module instr_sequencer #(
    parameter int PC_W      = 8,
    parameter int NUM_UNITS = 7,
    parameter int WAIT_MAX  = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    instr_sequencer_if.master     bus,
    output logic                  halted,
    output logic                  fault,
    output logic [2:0]            state
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_DECODE = 3'd3,
        ST_EXEC   = 3'd4,
        ST_HALT   = 3'd5,
        ST_FAULT  = 3'd6
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t               state_reg, state_next;
    logic [PC_W-1:0]      pc_reg, pc_next;
    logic [15:0]          instr_reg, instr_next;
    logic [3:0]           opcode;
    logic [NUM_UNITS-1:0] done_vec;
    logic                 any_done;
    logic                 wd_expire;

    assign opcode = instr_reg[15:12];

    generate
        for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_done
            assign done_vec[gi] = bus.unit_done[gi];
        end
    endgenerate

    assign any_done = |done_vec;

`ifdef SEQ_WATCHDOG_EN
    localparam int WD_W = ($clog2(WAIT_MAX + 1) > 8) ? $clog2(WAIT_MAX + 1) : 8;

    logic [WD_W-1:0] wd_cnt_reg, wd_cnt_next;

    // Counter rests at zero outside EXEC, so it is clear on every EXEC entry.
    always_comb begin
        wd_cnt_next = '0;
        if (state_reg == ST_EXEC && !any_done) begin
            wd_cnt_next = wd_cnt_reg + WD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_reg <= '0;
        end else begin
            wd_cnt_reg <= wd_cnt_next;
        end
    end

    // Expires on the idle EXEC cycle that would bring the count to WAIT_MAX;
    // a done in that same cycle wins (checked first in the FSM).
    assign wd_expire = (wd_cnt_reg == WD_W'(WAIT_MAX - 1));
`else
    assign wd_expire = 1'b0;
`endif

    // Keeps WAIT_MAX referenced in builds without the watchdog.
    logic unused_wait_max;
    assign unused_wait_max = (WAIT_MAX > 0);

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        instr_next = instr_reg;
        case (state_reg)
            ST_IDLE: begin
                if (run) state_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (bus.mem_valid) begin
                    instr_next = bus.mem_data;
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_next = ST_DECODE;
            end
            ST_DECODE: begin
                if (opcode == OP_HALT) begin
                    state_next = ST_HALT;
                end else if (opcode == OP_NOP) begin
                    pc_next    = pc_reg + PC_W'(1);
                    state_next = run ? ST_FETCH : ST_IDLE;
                end else begin
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (any_done) begin
                    pc_next    = pc_reg + PC_W'(1);
                    state_next = run ? ST_FETCH : ST_IDLE;
                end else if (wd_expire) begin
                    state_next = ST_FAULT;
                end
            end
            ST_HALT:  state_next = ST_HALT;
            ST_FAULT: state_next = ST_FAULT;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            pc_reg    <= '0;
            instr_reg <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            instr_reg <= instr_next;
        end
    end

    // Strobes are decoded from the registered state only, so reset clears
    // them immediately and no input reaches an output combinationally.
    assign bus.mem_rd    = (state_reg == ST_FETCH);
    assign bus.ir_load   = (state_reg == ST_LOAD);
    assign bus.exec_en   = (state_reg == ST_EXEC);
    assign bus.pc        = pc_reg;
    assign bus.instr_out = instr_reg;
    assign halted        = (state_reg == ST_HALT);
    assign fault         = (state_reg == ST_FAULT);
    assign state         = state_reg;

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;

`ifdef SEQ_WATCHDOG_EN
    localparam int TB_WAIT_MAX = 4;
`else
    localparam int TB_WAIT_MAX = 255;
`endif

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_LOAD   = 3'd2;
    localparam logic [2:0] S_DECODE = 3'd3;
    localparam logic [2:0] S_EXEC   = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;
    localparam logic [2:0] S_FAULT  = 3'd6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       run = 1'b0;
    logic       halted;
    logic       fault;
    logic [2:0] state;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: just the architectural program counter.
    logic [7:0] model_pc = 8'h00;

    instr_sequencer_if #(.PC_W(8), .NUM_UNITS(7)) bus ();

    instr_sequencer #(
        .PC_W      (8),
        .NUM_UNITS (7),
        .WAIT_MAX  (TB_WAIT_MAX)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (run),
        .bus    (bus),
        .halted (halted),
        .fault  (fault),
        .state  (state)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Asserts reset mid-cycle and checks the asynchronous clear, then releases
    // on the next falling edge. Leaves the DUT in IDLE with run low.
    task automatic apply_reset();
        run   = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("rst_state",   state, S_IDLE);
        check_eq("rst_pc",      bus.pc, 8'h00);
        check_eq("rst_instr",   bus.instr_out, 16'h0000);
        check_eq("rst_mem_rd",  bus.mem_rd, 1'b0);
        check_eq("rst_ir_load", bus.ir_load, 1'b0);
        check_eq("rst_exec_en", bus.exec_en, 1'b0);
        check_eq("rst_halted",  halted, 1'b0);
        check_eq("rst_fault",   fault, 1'b0);
        @(negedge clk);
        rst_n         = 1'b1;
        bus.mem_valid = 1'b0;
        bus.unit_done = '0;
        model_pc      = 8'h00;
        @(negedge clk);
        check_eq("idle_hold", state, S_IDLE);
    endtask

    // From IDLE: raise run and expect FETCH one cycle later.
    task automatic start_run();
        check_eq("idle_mem_rd", bus.mem_rd, 1'b0);
        run = 1'b1;
        @(negedge clk);
        check_eq("start_fetch", state, S_FETCH);
    endtask

    // Executes one instruction starting from FETCH. mem_wait = cycles before
    // mem_valid, done_wait = idle EXEC cycles before a done pulse.
    task automatic do_instr(input logic [15:0] word, input int mem_wait,
                            input int done_wait, input bit run_after);
        logic [3:0] op;
        logic [2:0] after_state;
        op          = word[15:12];
        after_state = run_after ? S_FETCH : S_IDLE;

        check_eq("fetch_state", state, S_FETCH);
        check_eq("fetch_mem_rd", bus.mem_rd, 1'b1);
        check_eq("fetch_pc", bus.pc, model_pc);
        for (int w = 0; w < mem_wait; w++) begin
            bus.mem_valid = 1'b0;
            bus.mem_data  = 16'($urandom);
            bus.unit_done = 7'($urandom);
            @(negedge clk);
            check_eq("fetch_wait", state, S_FETCH);
        end
        bus.mem_valid = 1'b1;
        bus.mem_data  = word;
        bus.unit_done = 7'($urandom);
        @(negedge clk);

        // LOAD: stray mem_valid / unit_done must be ignored
        check_eq("load_ir_load", bus.ir_load, 1'b1);
        check_eq("load_instr", bus.instr_out, word);
        check_eq("load_state", state, S_LOAD);
        bus.mem_valid = 1'($urandom);
        bus.mem_data  = 16'($urandom);
        bus.unit_done = 7'($urandom);
        @(negedge clk);

        // DECODE
        check_eq("dec_ir_load", bus.ir_load, 1'b0);
        check_eq("dec_state", state, S_DECODE);
        check_eq("dec_instr", bus.instr_out, word);
        run           = run_after;
        bus.mem_valid = 1'($urandom);
        bus.unit_done = 7'($urandom);
        @(negedge clk);
        bus.mem_valid = 1'b0;

        if (op == 4'hF) begin
            bus.unit_done = '0;
            check_eq("halt_halted", halted, 1'b1);
            check_eq("halt_state", state, S_HALT);
            check_eq("halt_pc", bus.pc, model_pc);
        end else if (op == 4'h0) begin
            bus.unit_done = '0;
            model_pc = model_pc + 8'd1;
            check_eq("nop_exec_en", bus.exec_en, 1'b0);
            check_eq("nop_state", state, after_state);
            check_eq("nop_pc", bus.pc, model_pc);
        end else begin
            for (int d = 0; d <= done_wait; d++) begin
                check_eq("exec_state", state, S_EXEC);
                check_eq("exec_en", bus.exec_en, 1'b1);
                check_eq("exec_pc", bus.pc, model_pc);
                check_eq("exec_fault", fault, 1'b0);
                bus.unit_done = (d == done_wait) ? 7'($urandom_range(1, 127)) : 7'd0;
                @(negedge clk);
            end
            bus.unit_done = '0;
            model_pc = model_pc + 8'd1;
            check_eq("done_exec_en", bus.exec_en, 1'b0);
            check_eq("done_state", state, after_state);
            check_eq("done_pc", bus.pc, model_pc);
        end
        check_eq("after_mem_rd", bus.mem_rd, (op != 4'hF) && run_after);
        $display("txn word=%h mem_wait=%0d done_wait=%0d run=%0d pc_now=%h",
                 word, mem_wait, done_wait, run_after, bus.pc);
    endtask

    initial begin
        int         n;
        logic [15:0] w;
        bit          ra;

        bus.mem_valid = 1'b0;
        bus.mem_data  = '0;
        bus.unit_done = '0;
        #2;
        apply_reset();

        // Single dispatched instruction, zero wait, done in first EXEC cycle
        start_run();
        do_instr(16'h1002, 0, 0, 1'b0);
        check_eq("t1_pc", bus.pc, 8'h01);

        // 523F / NOP / 3005 with 2-cycle memory; run dropped before 3005 completes
        apply_reset();
        start_run();
        do_instr(16'h523F, 2, 1, 1'b1);
        do_instr(16'h0000, 2, 0, 1'b1);
        do_instr(16'h3005, 2, 2, 1'b0);
        check_eq("t2_pc", bus.pc, 8'h03);
        @(negedge clk);
        check_eq("t2_idle_state", state, S_IDLE);
        check_eq("t2_idle_mem_rd", bus.mem_rd, 1'b0);

        // HALT at pc=5
        apply_reset();
        start_run();
        for (int i = 0; i < 5; i++) begin
            do_instr({4'($urandom_range(0, 14)), 12'($urandom)}, $urandom_range(0, 2),
                     $urandom_range(0, 3), 1'b1);
        end
        do_instr(16'hF000, 1, 0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            run           = 1'($urandom);
            bus.mem_valid = 1'($urandom);
            bus.unit_done = 7'($urandom);
            @(negedge clk);
            check_eq("halt_stay", state, S_HALT);
            check_eq("halt_stay_pc", bus.pc, 8'h05);
            check_eq("halt_stay_mem_rd", bus.mem_rd, 1'b0);
        end
        apply_reset();

        // Randomized run long enough to wrap the 8-bit pc
        start_run();
        for (int i = 0; i < 320; i++) begin
            w = {4'($urandom_range(0, 14)), 12'($urandom)};
            if (model_pc == 8'hFF) w = 16'h0ABC;
            ra = ($urandom_range(0, 3) != 0);
            do_instr(w, $urandom_range(0, 3), $urandom_range(0, 3), ra);
            if (!ra) begin
                n = $urandom_range(0, 2);
                for (int k = 0; k < n; k++) begin
                    @(negedge clk);
                    check_eq("rand_idle", state, S_IDLE);
                end
                start_run();
            end
        end

        // Reset asserted while in FETCH
        bus.mem_valid = 1'b0;
        apply_reset();

        // Watchdog behaviour
        start_run();
`ifdef SEQ_WATCHDOG_EN
        bus.mem_valid = 1'b1;
        bus.mem_data  = 16'h1002;
        @(negedge clk);
        bus.mem_valid = 1'b0;
        @(negedge clk);
        bus.unit_done = '0;
        n = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (state == S_EXEC) n++;
            else break;
        end
        check_eq("wd_exec_cycles", n, 4);
        check_eq("wd_fault", fault, 1'b1);
        check_eq("wd_state", state, S_FAULT);
        check_eq("wd_exec_en", bus.exec_en, 1'b0);
        for (int k = 0; k < 3; k++) begin
            run           = 1'($urandom);
            bus.unit_done = 7'($urandom);
            @(negedge clk);
            check_eq("wd_stay", state, S_FAULT);
        end
        apply_reset();
        start_run();
        do_instr(16'h1002, 0, 3, 1'b1);
        check_eq("wd_done_no_fault", fault, 1'b0);
`else
        do_instr(16'h1002, 0, 40, 1'b1);
        check_eq("nowd_no_fault", fault, 1'b0);
`endif
        check_eq("wd_final_pc", bus.pc, 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
